// File: rtl/sync_fifo_flags_pkg.sv
// Shared constants for the flagged synchronous FIFO.
// Default widths, depth and level thresholds.
package sync_fifo_flags_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_BITS  = 4;
  localparam int DEF_DEPTH      = 1 << DEF_ADDR_BITS;
  localparam int DEF_AF_LEVEL   = 12;
  localparam int DEF_AE_LEVEL   = 2;
  localparam int DEF_SHOW_AHEAD = 1;

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// Dual-port storage for the FIFO.
// Synchronous write, combinational read.
module fifo_mem
  import sync_fifo_flags_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_BITS-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_BITS-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // store the write word; contents survive reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with level flags and sticky errors.
// Head word is either show-ahead or registered.
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int AF_LEVEL   = DEF_AF_LEVEL,
  parameter int AE_LEVEL   = DEF_AE_LEVEL,
  parameter int SHOW_AHEAD = DEF_SHOW_AHEAD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic [ADDR_BITS:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] C_FULL = DEPTH[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] C_AF = AF_LEVEL[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] C_AE = AE_LEVEL[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] C_CNT_ONE =
    {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] C_PTR_ONE =
    {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [ADDR_BITS-1:0]  r_wr_ptr;
  logic [ADDR_BITS-1:0]  r_rd_ptr;
  logic [ADDR_BITS:0]    r_count;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  w_do_wr;
  logic                  w_do_rd;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

  // a read frees a slot, so a full FIFO still takes a paired write
  assign w_do_rd = rd_en & ~w_empty;
  assign w_do_wr = wr_en & (~w_full | w_do_rd);

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_do_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // advance pointers on accepted operations only
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  // occupancy counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      unique case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // sticky errors; clear wins over a new error
  always_ff @(posedge clk) begin
    if (reset || clr_err) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (wr_en && !w_do_wr) r_ovf <= 1'b1;
      if (rd_en && w_empty)  r_unf <= 1'b1;
    end
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      assign data_out = w_rd_data;
      assign rd_valid = 1'b0;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_vld;

      // capture the head word on each pop
      always_ff @(posedge clk) begin
        if (reset) begin
          r_dout <= '0;
          r_vld  <= 1'b0;
        end else begin
          r_vld <= w_do_rd;
          if (w_do_rd) r_dout <= w_rd_data;
        end
      end

      assign data_out = r_dout;
      assign rd_valid = r_vld;
    end
  endgenerate

  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised self-checking bench for sync_fifo_flags.
// A queue-based model supplies every expected value.
module tb_sync_fifo_flags;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        rd_valid;
  logic [4:0]  count;
  logic        full, empty, af, ae, ovf, unf;

  logic        wr1 = 1'b0;
  logic        rd1 = 1'b0;
  logic [15:0] din1 = '0;
  logic [15:0] dout1;
  logic        vld1;
  logic [4:0]  cnt1;
  logic        full1, empty1, af1, ae1, ovf1, unf1;

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] q[$];
  bit          m_ovf = 0;
  bit          m_unf = 0;

  always #5 clk = ~clk;

  sync_fifo_flags dut0 (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_in      (data_in),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (af),
    .almost_empty (ae),
    .overflow     (ovf),
    .underflow    (unf)
  );

  sync_fifo_flags #(.SHOW_AHEAD(0)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr1),
    .rd_en        (rd1),
    .data_in      (din1),
    .clr_err      (1'b0),
    .data_out     (dout1),
    .rd_valid     (vld1),
    .count        (cnt1),
    .full         (full1),
    .empty        (empty1),
    .almost_full  (af1),
    .almost_empty (ae1),
    .overflow     (ovf1),
    .underflow    (unf1)
  );

  task automatic step(input logic w, input logic r,
                      input logic [15:0] d, input logic c);
    int n;
    bit dr, dw;
    wr_en = w; rd_en = r; data_in = d; clr_err = c;
    n  = q.size();
    dr = r && (n > 0);
    dw = w && ((n < 16) || dr);
    @(posedge clk); #1;
    if (c) begin
      m_ovf = 0; m_unf = 0;
    end else begin
      if (w && !dw) m_ovf = 1;
      if (r && n == 0) m_unf = 1;
    end
    if (dr) void'(q.pop_front());
    if (dw) q.push_back(d);
    wr_en = 0; rd_en = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wr_en = 0; rd_en = 0; clr_err = 0;
    wr1 = 0; rd1 = 0;
    q.delete();
    m_ovf = 0; m_unf = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (count !== 5'd0 || empty !== 1'b1 || ae !== 1'b1)
      $display("FAIL reset_level cnt=%0d e=%b ae=%b want 0 1 1",
               count, empty, ae);
    else n_pass++;
    n_chk++;
    if (full !== 1'b0 || af !== 1'b0)
      $display("FAIL reset_full f=%b af=%b want 0 0", full, af);
    else n_pass++;
    n_chk++;
    if (ovf !== 1'b0 || unf !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL reset_err o=%b u=%b v=%b want 0 0 0",
               ovf, unf, rd_valid);
    else n_pass++;
    n_chk++;
    if (dout1 !== 16'h0 || vld1 !== 1'b0 || empty1 !== 1'b1)
      $display("FAIL reset_reg d=%h v=%b e=%b want 0000 0 1",
               dout1, vld1, empty1);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) step(1, 0, 16'(i), 0);
    n_chk++;
    if (full !== 1'b1 || count !== 5'd16)
      $display("FAIL fill_full f=%b cnt=%0d want 1 16", full, count);
    else n_pass++;
    step(1, 0, 16'hDEAD, 0);
    n_chk++;
    if (ovf !== 1'b1 || count !== 5'd16)
      $display("FAIL fill_ovf o=%b cnt=%0d want 1 16", ovf, count);
    else n_pass++;
  endtask

  task automatic test_drain();
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (data_out !== 16'(i) && bad == 0) begin
        bad = 1;
        $display("FAIL drain_data idx=%0d got %h want %h",
                 i, data_out, 16'(i));
      end
      step(0, 1, 16'h0, 0);
    end
    n_chk++;
    if (bad == 0) n_pass++;
    n_chk++;
    if (empty !== 1'b1 || count !== 5'd0)
      $display("FAIL drain_empty e=%b cnt=%0d want 1 0", empty, count);
    else n_pass++;
    step(0, 1, 16'h0, 0);
    n_chk++;
    if (unf !== 1'b1 || count !== 5'd0)
      $display("FAIL drain_unf u=%b cnt=%0d want 1 0", unf, count);
    else n_pass++;
    step(0, 0, 16'h0, 1);
    n_chk++;
    if (ovf !== 1'b0 || unf !== 1'b0)
      $display("FAIL clr_err o=%b u=%b want 0 0", ovf, unf);
    else n_pass++;
  endtask

  task automatic test_full_rw();
    int bad = 0;
    logic [15:0] exp;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 16'hFFFF, 0);
      step(0, 1, 16'h0, 0);
    end
    for (int i = 0; i < 16; i++) step(1, 0, 16'h100 + 16'(i), 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 16'h200 + 16'(i), 0);
      if (count !== 5'd16 && bad == 0) begin
        bad = 1;
        $display("FAIL fullrw_cnt got %0d want 16", count);
      end
    end
    n_chk++;
    if (bad == 0 && ovf === 1'b0) n_pass++;
    else if (bad == 0) $display("FAIL fullrw_ovf got %b want 0", ovf);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 8) ? 16'h108 + 16'(i) : 16'h200 + 16'(i - 8);
      if (data_out !== exp && bad == 0) begin
        bad = 1;
        $display("FAIL fullrw_order idx=%0d got %h want %h",
                 i, data_out, exp);
      end
      step(0, 1, 16'h0, 0);
    end
    n_chk++;
    if (bad == 0) n_pass++;
  endtask

  task automatic test_thresholds();
    int bad = 0;
    bit eaf, eae;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step(1, 0, 16'(k * 3), 0);
      eaf = (k >= 12);
      eae = (k <= 2);
      if ((af !== eaf || ae !== eae || count !== 5'(k)) && bad == 0) begin
        bad = 1;
        $display("FAIL thresh k=%0d af=%b ae=%b cnt=%0d want %b %b %0d",
                 k, af, ae, count, eaf, eae, k);
      end
    end
    n_chk++;
    if (bad == 0) n_pass++;
  endtask

  task automatic test_clr_priority();
    for (int i = 0; i < 4; i++) step(1, 0, 16'h77, 0);
    step(1, 0, 16'h88, 1);
    n_chk++;
    if (ovf !== 1'b0 || count !== 5'd16)
      $display("FAIL clr_prio o=%b cnt=%0d want 0 16", ovf, count);
    else n_pass++;
    step(1, 0, 16'h88, 0);
    n_chk++;
    if (ovf !== 1'b1)
      $display("FAIL clr_then_ovf got %b want 1", ovf);
    else n_pass++;
  endtask

  task automatic test_registered();
    wr1 = 1; din1 = 16'hA5A5;
    @(posedge clk); #1;
    wr1 = 0;
    n_chk++;
    if (vld1 !== 1'b0 || cnt1 !== 5'd1)
      $display("FAIL reg_pre v=%b cnt=%0d want 0 1", vld1, cnt1);
    else n_pass++;
    rd1 = 1;
    @(posedge clk); #1;
    rd1 = 0;
    n_chk++;
    if (dout1 !== 16'hA5A5 || vld1 !== 1'b1)
      $display("FAIL reg_pop d=%h v=%b want a5a5 1", dout1, vld1);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (vld1 !== 1'b0 || dout1 !== 16'hA5A5 || empty1 !== 1'b1)
      $display("FAIL reg_after v=%b d=%h e=%b want 0 a5a5 1",
               vld1, dout1, empty1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(0, 1, 16'h0, 0);
    n_chk++;
    if (unf !== 1'b1)
      $display("FAIL mid_unf got %b want 1", unf);
    else n_pass++;
    wr1 = 1; din1 = 16'h5A5A;
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 16'h300 + 16'(i), 0);
      wr1 = 0;
    end
    n_chk++;
    if (count !== 5'd7)
      $display("FAIL mid_cnt got %0d want 7", count);
    else n_pass++;
    wr_en = 1; data_in = 16'h3FF; rd1 = 1;
    do_reset();
    n_chk++;
    if (count !== 5'd0 || empty !== 1'b1)
      $display("FAIL mid_rst cnt=%0d e=%b want 0 1", count, empty);
    else n_pass++;
    n_chk++;
    if (ovf !== 1'b0 || unf !== 1'b0)
      $display("FAIL mid_err o=%b u=%b want 0 0", ovf, unf);
    else n_pass++;
    n_chk++;
    if (vld1 !== 1'b0 || dout1 !== 16'h0 || cnt1 !== 5'd0)
      $display("FAIL mid_reg v=%b d=%h cnt=%0d want 0 0000 0",
               vld1, dout1, cnt1);
    else n_pass++;
  endtask

  task automatic test_random();
    int n;
    int bad = 0;
    bit w, r, c;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (q.size() > 0 && data_out !== q[0] && bad < 5) begin
        bad++;
        $display("FAIL rand_head cyc=%0d got %h want %h",
                 i, data_out, q[0]);
      end
      w = (i < 300) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      r = (i < 300) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      c = ($urandom_range(15) == 0);
      step(w, r, 16'($urandom), c);
      n = q.size();
      if ((count !== 5'(n) || full !== (n == 16) || empty !== (n == 0) ||
           af !== (n >= 12) || ae !== (n <= 2) ||
           ovf !== m_ovf || unf !== m_unf) && bad < 5) begin
        bad++;
        $display("FAIL rand_flags cyc=%0d cnt=%0d f%b e%b af%b ae%b o%b u%b want %0d %b %b %b %b %b %b",
                 i, count, full, empty, af, ae, ovf, unf,
                 n, n == 16, n == 0, n >= 12, n <= 2, m_ovf, m_unf);
      end
    end
    n_chk++;
    if (bad == 0) n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_thresholds();
    test_clr_priority();
    test_registered();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
